// File: rtl/regfile_wb_sequencer.sv
// Writeback sequencer for the SEQ register file: serialises E/M results
// onto one write port and bypasses pending values to the decode reads.
module regfile_wb_sequencer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter logic [ADDR_W-1:0] RNONE = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    input  logic [DATA_W-1:0] rf_rdataA,
    input  logic [DATA_W-1:0] rf_rdataB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WR_E, WR_M} state_t;

    state_t            state;
    logic [ADDR_W-1:0] hE_addr;
    logic [DATA_W-1:0] hE_data;
    logic [ADDR_W-1:0] hM_addr;
    logic [DATA_W-1:0] hM_data;

    logic              accept;
    logic [ADDR_W-1:0] capE;
    logic              empty;
    logic              pendE;
    logic              pendM;

    assign wb_ready = (state == IDLE) || (state == WR_M) ||
                      (state == WR_E && hM_addr == RNONE);
    assign accept   = wb_valid && wb_ready;

    // Same destination on both ports: the load result (M) wins.
    assign capE  = (dstE == dstM) ? RNONE : dstE;
    assign empty = (capE == RNONE) && (dstM == RNONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hE_addr <= RNONE;
            hE_data <= '0;
            hM_addr <= RNONE;
            hM_data <= '0;
        end else if (accept) begin
            if (!empty) begin
                hE_addr <= capE;
                hE_data <= valE;
                hM_addr <= dstM;
                hM_data <= valM;
            end
            if (capE != RNONE)
                state <= WR_E;
            else if (dstM != RNONE)
                state <= WR_M;
            else
                state <= IDLE;
        end else begin
            unique case (state)
                WR_E:    state <= (hM_addr != RNONE) ? WR_M : IDLE;
                WR_M:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = RNONE;
        rf_wdata = '0;
        unique case (state)
            WR_E: begin
                rf_we    = 1'b1;
                rf_waddr = hE_addr;
                rf_wdata = hE_data;
            end
            WR_M: begin
                rf_we    = 1'b1;
                rf_waddr = hM_addr;
                rf_wdata = hM_data;
            end
            default: ;
        endcase
    end

    assign busy  = (state != IDLE);
    assign pendE = (state == WR_E) && (hE_addr != RNONE);
    assign pendM = (state == WR_E || state == WR_M) && (hM_addr != RNONE);

    function automatic logic [DATA_W-1:0] bypass(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] raw
    );
        if (src == RNONE)
            return '0;
        else if (pendM && hM_addr == src)
            return hM_data;
        else if (pendE && hE_addr == src)
            return hE_data;
        else
            return raw;
    endfunction

    assign valA = bypass(srcA, rf_rdataA);
    assign valB = bypass(srcB, rf_rdataB);

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Scoreboard bench: expected writes queued at issue, popped by a monitor
// on every rf_we cycle; directed checks cover stall, bypass and reset.
module tb_regfile_wb_sequencer;

    logic        clk = 0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  dstE, dstM, srcA, srcB;
    logic [63:0] valE, valM, rf_rdataA, rf_rdataB;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] valA, valB;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [3:0]  exp_addr[$];
    logic [63:0] exp_data[$];
    int          wcyc[$];

    regfile_wb_sequencer dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .srcA(srcA), .srcB(srcB),
        .rf_rdataA(rf_rdataA), .rf_rdataB(rf_rdataB),
        .valA(valA), .valB(valB), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every committed write must match the head of the queue.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            wcyc.push_back(cyc);
            if (exp_addr.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got %h:%h expected none",
                         rf_waddr, rf_wdata);
            end else begin
                chk("wr_addr", {60'd0, rf_waddr}, {60'd0, exp_addr.pop_front()});
                chk("wr_data", rf_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic expect_wr(input logic [3:0] a, input logic [63:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // Offer a bundle; returns 1ns after the accepting edge with wb_valid low.
    task automatic send(input logic [3:0] e, input logic [63:0] ve,
                        input logic [3:0] m, input logic [63:0] vm);
        int n = 0;
        wb_valid = 1; dstE = e; valE = ve; dstM = m; valM = vm;
        while (wb_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        wb_valid = 0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; wb_valid = 0;
        dstE = 4'hF; dstM = 4'hF; valE = 0; valM = 0;
        srcA = 4'hF; srcB = 4'hF;
        rf_rdataA = 64'hAAAA; rf_rdataB = 64'hBBBB;
        #12;
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_waddr", {60'd0, rf_waddr}, 64'hF);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, wb_ready}, 64'd1);
        @(negedge clk); rst = 0;
        tick;

        // E-only bundle: one write, one busy cycle, ready throughout.
        expect_wr(4'd4, 64'h100);
        send(4'd4, 64'h100, 4'hF, 64'h0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_ready", {63'd0, wb_ready}, 64'd1);
        tick;
        chk("t1_busy_after", {63'd0, busy}, 64'd0);
        chk("t1_we_after", {63'd0, rf_we}, 64'd0);

        // E+M bundle: stall during WR_E, bypass of pending M and E.
        expect_wr(4'd4, 64'h20);
        expect_wr(4'd3, 64'h77);
        rf_rdataA = 64'hDEAD; rf_rdataB = 64'hBEEF;
        send(4'd4, 64'h20, 4'd3, 64'h77);
        srcA = 4'd3; srcB = 4'd4; #1;
        chk("t2_ready_wrE", {63'd0, wb_ready}, 64'd0);
        chk("t2_valA_wrE", valA, 64'h77);
        chk("t2_valB_wrE", valB, 64'h20);
        tick;
        chk("t2_ready_wrM", {63'd0, wb_ready}, 64'd1);
        chk("t2_valA_wrM", valA, 64'h77);
        chk("t2_valB_wrM", valB, 64'hBEEF);
        tick;
        chk("t2_valA_idle", valA, 64'hDEAD);

        // Duplicate destination: only the M value is written.
        expect_wr(4'd4, 64'h99);
        send(4'd4, 64'h10, 4'd4, 64'h99);
        srcA = 4'd4; #1;
        chk("t3_valA", valA, 64'h99);
        tick;
        chk("t3_busy_after", {63'd0, busy}, 64'd0);

        // Back-to-back bundles, last one empty.
        tick;
        wcyc.delete();
        expect_wr(4'd1, 64'hA);
        expect_wr(4'd2, 64'hB);
        expect_wr(4'd5, 64'hC);
        send(4'd1, 64'hA, 4'hF, 64'h0);
        send(4'd2, 64'hB, 4'd5, 64'hC);
        send(4'hF, 64'h0, 4'hF, 64'h0);
        tick; tick;
        chk("t4_nwrites", wcyc.size(), 64'd3);
        if (wcyc.size() == 3) begin
            chk("t4_gap1", wcyc[1] - wcyc[0], 64'd1);
            chk("t4_gap2", wcyc[2] - wcyc[1], 64'd1);
        end
        chk("t4_busy_end", {63'd0, busy}, 64'd0);

        // Async reset in the middle of WR_E drops the pending M write.
        expect_wr(4'd6, 64'h60);
        send(4'd6, 64'h60, 4'd7, 64'h70);
        @(negedge clk); #3;
        rst = 1; #1;
        chk("t5_we", {63'd0, rf_we}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_ready", {63'd0, wb_ready}, 64'd1);
        chk("t5_waddr", {60'd0, rf_waddr}, 64'hF);
        @(negedge clk); rst = 0;
        tick; tick; tick;

        // Bypass with nothing pending.
        srcA = 4'hF; srcB = 4'd7;
        rf_rdataA = 64'h33; rf_rdataB = 64'h55; #1;
        chk("t6_valA", valA, 64'h0);
        chk("t6_valB", valB, 64'h55);

        chk("queue_drained", exp_addr.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
